branch_resolve_unit: RTL and testbench

Parametrised, registered branch resolution unit for the RV32IM pipeline, placed at the EX/MEM boundary. Evaluates branch/jump conditions on XLEN-wide operands and compares the outcome with the fetch-stage prediction. Raises a one-cycle redirect/flush on misprediction, then squashes wrong-path branch issues for a fixed shadow window. Owns a 2-bit saturating branch history table (BHT) that fetch reads combinationally and that is trained on every resolved conditional branch.

---
 rtl/branch_resolve_unit_if.sv | 40 ++++
 rtl/branch_resolve_unit.sv | 143 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Issue, lookup, resolution and statistics bundle for branch_resolve_unit.
// Master drives the issue/lookup side; slave is the resolve unit.
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [XLEN-1:0]  data1;
  logic [XLEN-1:0]  data2;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  target;
  logic             pred_taken;
  logic [XLEN-1:0]  lu_pc;
  logic             lu_taken;
  logic             res_valid;
  logic             res_taken;
  logic             res_mispredict;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_mispredicts;

  modport master (
    output in_valid, op, data1, data2, pc, target,
    output pred_taken, lu_pc,
    input  in_ready, lu_taken, res_valid, res_taken,
    input  res_mispredict, redirect_pc, flush,
    input  stat_branches, stat_mispredicts
  );

  modport slave (
    input  in_valid, op, data1, data2, pc, target,
    input  pred_taken, lu_pc,
    output in_ready, lu_taken, res_valid, res_taken,
    output res_mispredict, redirect_pc, flush,
    output stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX/MEM branch resolution with 2-bit BHT, mispredict squash window.
// Define BR_UNIT_STATS_EN to build the branch/mispredict counters.
module branch_resolve_unit #(
  parameter int XLEN       = 32,
  parameter int BHT_IDX    = 6,
  parameter int SHADOW_CYC = 2,
  parameter int CNT_W      = 32
) (
  input  logic CLK,
  input  logic RESET,
  branch_resolve_unit_if.slave bus
);
  localparam int CW   = $clog2(SHADOW_CYC + 1);
  localparam int NENT = 2 ** BHT_IDX;

  typedef enum logic {S_RUN, S_SQUASH} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [1:0]      r_bht [NENT];
  logic            r_res_valid;
  logic            r_res_taken;
  logic            r_res_mis;
  logic            r_flush;
  logic [XLEN-1:0] r_redirect;

  logic             w_ready;
  logic             w_accept;
  logic             w_taken;
  logic             w_mis;
  logic             w_cond;
  logic [BHT_IDX-1:0] w_idx;
  logic [BHT_IDX-1:0] w_lu_idx;
  logic             w_unused_lu;

  assign w_ready  = (r_state == S_RUN);
  assign w_accept = bus.in_valid & w_ready;
  assign w_idx    = bus.pc[BHT_IDX+1:2];
  assign w_lu_idx = bus.lu_pc[BHT_IDX+1:2];
  assign w_cond   = (bus.op[2:1] != 2'b01);
  assign w_mis    = w_taken ^ bus.pred_taken;
  assign w_unused_lu = ^{bus.lu_pc[XLEN-1:BHT_IDX+2],
                         bus.lu_pc[1:0]};

  always_comb begin
    w_taken = 1'b0;
    unique case (bus.op)
      3'b000: w_taken = (bus.data1 == bus.data2);
      3'b001: w_taken = (bus.data1 != bus.data2);
      3'b100: w_taken = ($signed(bus.data1) <
                         $signed(bus.data2));
      3'b101: w_taken = ($signed(bus.data1) >=
                         $signed(bus.data2));
      3'b110: w_taken = (bus.data1 < bus.data2);
      3'b111: w_taken = (bus.data1 >= bus.data2);
      3'b010: w_taken = 1'b1;
      3'b011: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_RUN: begin
        if (w_accept && w_mis) begin
          w_state_nxt = S_SQUASH;
          w_cnt_nxt   = CW'(SHADOW_CYC);
        end
      end
      S_SQUASH: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_state_nxt = S_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= S_RUN;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_res_taken <= 1'b0;
      r_res_mis   <= 1'b0;
      r_flush     <= 1'b0;
      r_redirect  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_res_valid <= w_accept;
      r_res_mis   <= w_accept & w_mis;
      r_flush     <= w_accept & w_mis;
      if (w_accept) begin
        r_res_taken <= w_taken;
        r_redirect  <= w_taken ? bus.target
                               : bus.pc + XLEN'(4);
      end
    end
  end

  // Counters saturate at 00/11; unconditional ops never train.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NENT; i++) r_bht[i] <= 2'b01;
    end else if (w_accept && w_cond) begin
      if (w_taken && r_bht[w_idx] != 2'b11)
        r_bht[w_idx] <= r_bht[w_idx] + 2'b01;
      else if (!w_taken && r_bht[w_idx] != 2'b00)
        r_bht[w_idx] <= r_bht[w_idx] - 2'b01;
    end
  end

`ifdef BR_UNIT_STATS_EN
  logic [CNT_W-1:0] r_stat_br;
  logic [CNT_W-1:0] r_stat_mis;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_stat_br  <= '0;
      r_stat_mis <= '0;
    end else if (w_accept) begin
      r_stat_br <= r_stat_br + CNT_W'(1);
      if (w_mis) r_stat_mis <= r_stat_mis + CNT_W'(1);
    end
  end

  assign bus.stat_branches    = r_stat_br;
  assign bus.stat_mispredicts = r_stat_mis;
`else
  assign bus.stat_branches    = '0;
  assign bus.stat_mispredicts = '0;
`endif

  assign bus.in_ready       = w_ready;
  assign bus.lu_taken       = r_bht[w_lu_idx][1];
  assign bus.res_valid      = r_res_valid;
  assign bus.res_taken      = r_res_taken;
  assign bus.res_mispredict = r_res_mis;
  assign bus.redirect_pc    = r_redirect;
  assign bus.flush          = r_flush;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Random and directed checks of branch_resolve_unit against a model.
// Honours BR_UNIT_STATS_EN the same way as the design.
module tb_branch_resolve_unit;
  localparam int SH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  branch_resolve_unit_if #(.XLEN(32), .CNT_W(32)) bus ();

  branch_resolve_unit #(
    .XLEN(32), .BHT_IDX(6), .SHADOW_CYC(SH), .CNT_W(32)
  ) dut (
    .CLK(clk), .RESET(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int          mbht [64];
  int          cyc;
  int          ready_at;
  bit          e_rv, e_tk, e_mis;
  logic [31:0] e_red;
  logic [31:0] e_sb, e_sm;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit f_taken(logic [2:0] op,
                                 logic [31:0] a,
                                 logic [31:0] b);
    int sa = a;
    int sb = b;
    case (op)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      3'd2: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int lidx(logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  function automatic logic [31:0] stat_exp(logic [31:0] v);
`ifdef BR_UNIT_STATS_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk_out(string tag);
    chk({tag, "_rv"}, bus.res_valid, e_rv);
    chk({tag, "_tk"}, bus.res_taken, e_tk);
    chk({tag, "_mis"}, bus.res_mispredict, e_mis);
    chk({tag, "_fl"}, bus.flush, e_mis);
    chk({tag, "_red"}, bus.redirect_pc, e_red);
    chk({tag, "_sb"}, bus.stat_branches, stat_exp(e_sb));
    chk({tag, "_sm"}, bus.stat_mispredicts, stat_exp(e_sm));
  endtask

  task automatic do_cycle(bit iv, logic [2:0] op,
                          logic [31:0] a, logic [31:0] b,
                          logic [31:0] p, logic [31:0] t,
                          bit pr, output bit acc);
    bit tk;
    bus.in_valid = iv; bus.op = op;
    bus.data1 = a; bus.data2 = b;
    bus.pc = p; bus.target = t; bus.pred_taken = pr;
    #1;
    chk("ready", bus.in_ready, cyc >= ready_at);
    chk("lu", bus.lu_taken, mbht[lidx(bus.lu_pc)] >= 2);
    acc = iv && (cyc >= ready_at);
    e_rv = acc;
    e_mis = 1'b0;
    if (acc) begin
      tk = f_taken(op, a, b);
      e_tk = tk;
      e_mis = (tk != pr);
      e_red = tk ? t : p + 32'd4;
      e_sb = e_sb + 1;
      if (e_mis) begin
        e_sm = e_sm + 1;
        ready_at = cyc + 1 + SH;
      end
      if (op != 3'd2 && op != 3'd3) begin
        if (tk) mbht[lidx(p)] = (mbht[lidx(p)] == 3) ? 3 : mbht[lidx(p)] + 1;
        else    mbht[lidx(p)] = (mbht[lidx(p)] == 0) ? 0 : mbht[lidx(p)] - 1;
      end
    end
    @(posedge clk); #1;
    cyc++;
    chk_out("res");
  endtask

  task automatic issue(logic [2:0] op, logic [31:0] a,
                       logic [31:0] b, logic [31:0] p,
                       logic [31:0] t, bit pr);
    bit acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++)
      do_cycle(1'b1, op, a, b, p, t, pr, acc);
    chk("issue_timeout", acc, 1'b1);
  endtask

  task automatic idle(int n);
    bit acc;
    for (int k = 0; k < n; k++)
      do_cycle(1'b0, 3'd0, 0, 0, 0, 0, 1'b0, acc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    cyc++;
    for (int i = 0; i < 64; i++) mbht[i] = 1;
    ready_at = 0;
    e_rv = 0; e_tk = 0; e_mis = 0; e_red = 0;
    e_sb = 0; e_sm = 0;
    chk_out("rst");
    chk("rst_ready", bus.in_ready, 1'b1);
  endtask

  initial begin
    bit acc;
    logic [31:0] a, b, p;
    bus.in_valid = 0; bus.op = 0; bus.data1 = 0;
    bus.data2 = 0; bus.pc = 0; bus.target = 0;
    bus.pred_taken = 0; bus.lu_pc = 0;
    cyc = 0;
    @(posedge clk); #1;
    do_reset();

    // first mispredict and squash window
    bus.lu_pc = 32'h100;
    #1 chk("lu_init", bus.lu_taken, 1'b0);
    issue(3'd0, 5, 5, 32'h100, 32'h200, 1'b0);
    chk("d1_tk", bus.res_taken, 1'b1);
    chk("d1_fl", bus.flush, 1'b1);
    chk("d1_red", bus.redirect_pc, 32'h200);
    for (int k = 0; k < SH; k++) begin
      do_cycle(1'b1, 3'd0, 1, 2, 32'h104, 32'h300, 1'b0, acc);
      chk("sq_noacc", acc, 1'b0);
      chk("sq_rv", bus.res_valid, 1'b0);
    end
    do_cycle(1'b1, 3'd0, 1, 2, 32'h104, 32'h300, 1'b0, acc);
    chk("sq_end_rv", bus.res_valid, 1'b1);

    // signed vs unsigned, pc wrap
    issue(3'd4, 32'hFFFFFFFF, 1, 32'h500, 32'h600, 1'b1);
    chk("slt_tk", bus.res_taken, 1'b1);
    issue(3'd6, 32'hFFFFFFFF, 1, 32'hFFFFFFFC, 32'h600, 1'b0);
    chk("ltu_tk", bus.res_taken, 1'b0);
    chk("ltu_fl", bus.flush, 1'b0);
    chk("ltu_red", bus.redirect_pc, 32'h0);

    // BHT saturation at pc 0x40
    bus.lu_pc = 32'h40;
    for (int k = 0; k < 4; k++)
      issue(3'd0, 7, 7, 32'h40, 32'h80, 1'b1);
    chk("bht_sat", bus.lu_taken, 1'b1);
    issue(3'd1, 7, 7, 32'h40, 32'h80, 1'b0);
    issue(3'd1, 7, 7, 32'h40, 32'h80, 1'b0);
    chk("bht_dn", bus.lu_taken, 1'b0);
    issue(3'd2, 0, 0, 32'h40, 32'h80, 1'b1);
    chk("bht_jal", bus.lu_taken, 1'b0);
    idle(1);

    // reset in the middle of a squash
    issue(3'd0, 1, 1, 32'h40, 32'h80, 1'b0);
    do_cycle(1'b1, 3'd0, 1, 1, 32'h44, 32'h80, 1'b0, acc);
    do_reset();
    #1 chk("rst_lu", bus.lu_taken, 1'b0);
    issue(3'd5, 3, 9, 32'h40, 32'h90, 1'b1);
    chk("rst_after_rv", bus.res_valid, 1'b1);
    chk("rst_after_red", bus.redirect_pc, 32'h44);

    // statistics: 10 accepts, 3 mispredicts
    do_reset();
    for (int k = 0; k < 10; k++)
      issue(3'd0, k, 4, 32'h200 + 4 * k, 32'h400,
            (k == 1 || k == 5 || k == 8) ? (k != 4) : (k == 4));
    chk("st_br", bus.stat_branches, stat_exp(10));
    chk("st_mis", bus.stat_mispredicts, stat_exp(3));

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      a = $urandom_range(0, 3) == 0 ? $urandom_range(0, 7)
                                    : $urandom;
      b = $urandom_range(0, 2) == 0 ? a
                                    : $urandom_range(0, 7);
      if ($urandom_range(0, 3) == 0) b = $urandom;
      p = {$urandom_range(0, 1) ? 24'h0 : 24'($urandom),
           2'b00, 4'($urandom_range(0, 3)), 2'b00};
      bus.lu_pc = {$urandom_range(0, 1) ? 24'h0 : 24'($urandom),
                   2'b00, 4'($urandom_range(0, 3)), 2'b00};
      do_cycle($urandom_range(0, 3) != 0, 3'($urandom),
               a, b, p, $urandom, 1'($urandom), acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
